// File: rtl/key_schedule_encryption.sv
// BORON encryption key schedule: loads an 80-bit master key and streams round keys 0..NROUNDS
// over valid/ready. Optional final key output is enabled by defining KEY_SCHED_FINAL_KEY_EN.
module key_schedule_encryption #(
  parameter int NROUNDS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key_in,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [63:0] rk_data,
  output logic [4:0]  rk_index,
  output logic        done
`ifdef KEY_SCHED_FINAL_KEY_EN
  ,
  output logic [79:0] final_key
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NROUNDS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [79:0] r_key;
  logic [79:0] w_key_nxt;
  logic [4:0]  r_round;
  logic [4:0]  w_round_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic        r_rk_valid;
  logic        w_rk_valid_nxt;
  logic [63:0] r_rk_data;
  logic [63:0] w_rk_data_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic [79:0] w_key_upd;
  logic        w_hs;
`ifdef KEY_SCHED_FINAL_KEY_EN
  logic [79:0] r_final_key;
  logic [79:0] w_final_key_nxt;
`endif

  function automatic logic [3:0] s_box_encryption(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hE;
      4'h1:    y = 4'h4;
      4'h2:    y = 4'hB;
      4'h3:    y = 4'h1;
      4'h4:    y = 4'h7;
      4'h5:    y = 4'h9;
      4'h6:    y = 4'hC;
      4'h7:    y = 4'hA;
      4'h8:    y = 4'hD;
      4'h9:    y = 4'h2;
      4'hA:    y = 4'h0;
      4'hB:    y = 4'hF;
      4'hC:    y = 4'h8;
      4'hD:    y = 4'h5;
      4'hE:    y = 4'h3;
      4'hF:    y = 4'h6;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Rotate left 13, substitute the low nibble, then mix the round counter into bits 63:59.
  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t        = {k[66:0], k[79:67]};
    t[3:0]   = s_box_encryption(t[3:0]);
    t[63:59] = t[63:59] ^ r;
    return t;
  endfunction

  assign w_key_upd = key_update(r_key, r_round);
  assign w_hs      = r_rk_valid & rk_ready;

  // Next-state and next-register values; rk_ready only reaches register inputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_key_nxt      = r_key;
    w_round_nxt    = r_round;
    w_busy_nxt     = r_busy;
    w_rk_valid_nxt = r_rk_valid;
    w_rk_data_nxt  = r_rk_data;
    w_done_nxt     = 1'b0;
`ifdef KEY_SCHED_FINAL_KEY_EN
    w_final_key_nxt = r_final_key;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_RUN;
          w_key_nxt      = key_in;
          w_round_nxt    = 5'd0;
          w_busy_nxt     = 1'b1;
          w_rk_valid_nxt = 1'b1;
          w_rk_data_nxt  = key_in[63:0];
`ifdef KEY_SCHED_FINAL_KEY_EN
          w_final_key_nxt = 80'd0;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_hs && (r_round == LAST_ROUND)) begin
          w_state_nxt    = S_DONE;
          w_rk_valid_nxt = 1'b0;
          w_done_nxt     = 1'b1;
`ifdef KEY_SCHED_FINAL_KEY_EN
          w_final_key_nxt = r_key;
`endif
        end else if (w_hs) begin
          w_key_nxt     = w_key_upd;
          w_round_nxt   = r_round + 5'd1;
          w_rk_data_nxt = w_key_upd[63:0];
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        // Return the visible outputs to their idle values.
        w_state_nxt   = S_IDLE;
        w_busy_nxt    = 1'b0;
        w_round_nxt   = 5'd0;
        w_rk_data_nxt = 64'd0;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_busy_nxt     = 1'b0;
        w_rk_valid_nxt = 1'b0;
        w_round_nxt    = 5'd0;
        w_rk_data_nxt  = 64'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Key, round counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key      <= 80'd0;
      r_round    <= 5'd0;
      r_busy     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= 64'd0;
      r_done     <= 1'b0;
    end else begin
      r_key      <= w_key_nxt;
      r_round    <= w_round_nxt;
      r_busy     <= w_busy_nxt;
      r_rk_valid <= w_rk_valid_nxt;
      r_rk_data  <= w_rk_data_nxt;
      r_done     <= w_done_nxt;
    end
  end

`ifdef KEY_SCHED_FINAL_KEY_EN
  // Final key state captured on the last handshake, used to seed the decryption schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_final_key <= 80'd0;
    end else begin
      r_final_key <= w_final_key_nxt;
    end
  end

  assign final_key = r_final_key;
`endif

  assign busy     = r_busy;
  assign rk_valid = r_rk_valid;
  assign rk_data  = r_rk_data;
  assign rk_index = r_round;
  assign done     = r_done;

endmodule
